// File: rtl/fft_stage_accum_if.sv
// Block-sum hand-off bus between the stage accumulator and the FFT output buffer.
// The master drives a completed block sum and holds it until the slave accepts it.
`timescale 1ns/1ps
interface fft_stage_accum_if #(
  parameter int ACC_W = 11
);
  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/fft_stage_accum.sv
// Stage accumulator placed behind the 4-register doubling pipeline.
// The pipeline carries no valid signal, so this block delays `start` by LATENCY
// cycles to find out which sum_in samples are real. It adds BLOCK of those
// samples into one block sum and offers the sum on a one-entry valid/ready slot.
// A block that completes while the slot is still full is dropped, and the drop
// is recorded in the sticky overflow flag.
`timescale 1ns/1ps
module fft_stage_accum #(
  parameter int width   = 4,
  parameter int LATENCY = 4,
  parameter int BLOCK   = 4,
  parameter int ACC_W   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [width+4:0]     sum_in,
  fft_stage_accum_if.master    out_bus,
  output logic                 busy,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(BLOCK);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t             state, state_next;
  logic [LATENCY-1:0] vld_line, vld_line_next;
  logic [ACC_W-1:0]   acc, acc_next;
  logic [ACC_W-1:0]   sum_ext, blk_value;
  logic [ACC_W-1:0]   out_data_q;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               out_valid_q;
  logic               samp, blk_done, accept;

  // Shifting left and OR-ing in start keeps this valid even when LATENCY is 1.
  assign vld_line_next = (vld_line << 1) | LATENCY'(start);
  assign samp          = vld_line[LATENCY-1];
  assign sum_ext       = ACC_W'(sum_in);
  assign accept        = out_valid_q && out_bus.out_ready;

  assign out_bus.out_data  = out_data_q;
  assign out_bus.out_valid = out_valid_q;

  // Rebuild sample alignment: start travels LATENCY flops to meet its sum_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_line <= '0;
    end else begin
      vld_line <= vld_line_next;
    end
  end

  // Next-state logic of the accumulator. Samples only count when samp is high,
  // and a block completes on its BLOCK-th aligned sample.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    blk_done   = 1'b0;
    blk_value  = acc + sum_ext;
    case (state)
      IDLE: begin
        if (samp) begin
          acc_next   = sum_ext;
          cnt_next   = CNT_W'(1);
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (samp) begin
          if (cnt == CNT_W'(BLOCK - 1)) begin
            blk_done   = 1'b1;
            acc_next   = '0;
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            acc_next = acc + sum_ext;
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        acc_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  // Accumulator state register; reset throws away any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
    end
  end

  // One-entry output slot. A completed block may refill the slot on the same
  // edge that the consumer empties it. Otherwise the block is dropped and the
  // drop is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow    <= 1'b0;
    end else if (blk_done) begin
      if (!out_valid_q || accept) begin
        out_data_q  <= blk_value;
        out_valid_q <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (accept) begin
      out_valid_q <= 1'b0;
    end
  end

  // busy is taken from the next-state values. After each edge it shows whether a
  // partial block or an in-flight sample is present.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= (state_next == ACCUM) || (vld_line_next != '0);
    end
  end

endmodule
